uart_echo_buf: RTL and testbench

UART_ECHO_BUF -- requirements
Module: uart_echo_buf

---
 rtl/uart_echo_buf.sv | 139 +++++++++++++
 tb/tb_uart_echo_buf.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_buf.sv
// UART echo buffer: queues received characters in a FIFO and replays them to the
// transmitter, either per character or a whole line at a time once TERM arrives.
module uart_echo_buf #(
  parameter int          DATA_BITS = 8,
  parameter int          DEPTH     = 16,
  parameter int          LINE_MODE = 0,
  parameter int unsigned TERM      = 8'h0D,
  parameter int unsigned LED_HOLD  = 8_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_BITS-1:0]   rx_data,
  input  logic                   rx_valid,
  output logic                   rx_flush,
  output logic [DATA_BITS-1:0]   tx_data,
  output logic                   tx_enable,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   led_rx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(LED_HOLD + 1);
  localparam logic [CW-1:0]        FULL     = CW'(DEPTH);
  localparam logic [DATA_BITS-1:0] TERM_CHR = DATA_BITS'(TERM);
  localparam logic [LW-1:0]        LED_LOAD = LW'(LED_HOLD);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d, term_q, term_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic [1:0]           wait_cnt_q, wait_cnt_d;
  logic [LW-1:0]        led_cnt_q, led_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 rx_flush_q, rx_flush_d;
  logic                 force_q, force_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic pop, wr_en, term_push, term_pop, full_noterm, permit;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      term_q     <= '0;
      tx_data_q  <= '0;
      wait_cnt_q <= '0;
      led_cnt_q  <= '0;
      overflow_q <= 1'b0;
      rx_flush_q <= 1'b0;
      force_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      term_q     <= term_d;
      tx_data_q  <= tx_data_d;
      wait_cnt_q <= wait_cnt_d;
      led_cnt_q  <= led_cnt_d;
      overflow_q <= overflow_d;
      rx_flush_q <= rx_flush_d;
      force_q    <= force_d;
    end
  end

  // A pop in LOAD frees a slot in the same cycle, so a write at full still fits.
  always_comb begin
    pop       = (state_q == LOAD);
    wr_en     = !rst && rx_valid && ((count_q != FULL) || pop);
    term_push = wr_en && (rx_data == TERM_CHR);
    term_pop  = pop && (mem_q[rd_ptr_q] == TERM_CHR);

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;

    term_d = term_q;
    if (term_push && !term_pop)      term_d = term_q + 1'b1;
    else if (!term_push && term_pop) term_d = term_q - 1'b1;

    overflow_d = overflow_q || (rx_valid && (count_q == FULL) && !pop);
    rx_flush_d = rx_valid;
    led_cnt_d  = wr_en ? LED_LOAD : ((led_cnt_q != '0) ? led_cnt_q - 1'b1 : led_cnt_q);
  end

  // A full buffer with no terminator would stall forever in line mode, so it is
  // drained completely (including late arrivals) before line gating resumes.
  always_comb begin
    full_noterm = (LINE_MODE != 0) && (count_q == FULL) && (term_q == '0);
    force_d     = (LINE_MODE != 0) && (force_q || full_noterm) && (count_d != '0);
    if (LINE_MODE == 0) permit = (count_q != '0);
    else                permit = (term_q != '0) || force_q || full_noterm;
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE:    if (permit && !tx_busy) state_d = LOAD;
      LOAD: begin
        tx_data_d = mem_q[rd_ptr_q];
        state_d   = START;
      end
      START: begin
        wait_cnt_d = '0;
        state_d    = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy || (wait_cnt_q == 2'd3)) state_d = WAIT_LO;
        else                                 wait_cnt_d = wait_cnt_q + 1'b1;
      end
      WAIT_LO: if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign rx_flush   = rx_flush_q;
  assign tx_data    = tx_data_q;
  assign tx_enable  = (state_q == START);
  assign led_rx     = (led_cnt_q != '0);

endmodule

// File: tb/tb_uart_echo_buf.sv
// Scoreboard bench for uart_echo_buf: one instance per echo mode, each with a
// simple transmitter model, a reference queue model and an independent monitor.
module tb_uart_echo_buf;

  localparam int          DEPTH    = 16;
  localparam int unsigned LED_HOLD = 20;
  localparam logic [7:0]  TERM     = 8'h0D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] rx_data_a = '0, rx_data_l = '0;
  logic       rx_valid_a = 1'b0, rx_valid_l = 1'b0;
  logic       rx_flush_a, rx_flush_l;
  logic [7:0] tx_data_a, tx_data_l;
  logic       tx_enable_a, tx_enable_l;
  logic       tx_busy_a, tx_busy_l;
  logic [4:0] fifo_count_a, fifo_count_l;
  logic       overflow_a, overflow_l, led_a, led_l;
  logic       busy_force_a = 1'b0, busy_force_l = 1'b0;
  logic       busy_model_a = 1'b0, busy_model_l = 1'b0;

  assign tx_busy_a = busy_force_a | busy_model_a;
  assign tx_busy_l = busy_force_l | busy_model_l;

  uart_echo_buf #(.DATA_BITS(8), .DEPTH(DEPTH), .LINE_MODE(0), .TERM(8'h0D), .LED_HOLD(LED_HOLD)) dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_flush(rx_flush_a),
    .tx_data(tx_data_a), .tx_enable(tx_enable_a), .tx_busy(tx_busy_a),
    .fifo_count(fifo_count_a), .overflow(overflow_a), .led_rx(led_a));

  uart_echo_buf #(.DATA_BITS(8), .DEPTH(DEPTH), .LINE_MODE(1), .TERM(8'h0D), .LED_HOLD(LED_HOLD)) dut_l (
    .clk(clk), .rst(rst), .rx_data(rx_data_l), .rx_valid(rx_valid_l), .rx_flush(rx_flush_l),
    .tx_data(tx_data_l), .tx_enable(tx_enable_l), .tx_busy(tx_busy_l),
    .fifo_count(fifo_count_l), .overflow(overflow_l), .led_rx(led_l));

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_a[$], exp_l[$], pend_l[$];
  int sent_a = 0, sent_l = 0, flush_cnt_a = 0, flush_cnt_l = 0, txen_cnt_a = 0, txen_cnt_l = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Line reference: characters wait until a terminator arrives or the buffer fills.
  task automatic line_model_write(input logic [7:0] d);
    pend_l.push_back(d);
    if (d == TERM || pend_l.size() == DEPTH)
      while (pend_l.size() != 0) exp_l.push_back(pend_l.pop_front());
  endtask

  task automatic apply_stimulus(input bit line, input logic [7:0] d, input bit accept, input int gap);
    @(negedge clk);
    if (!line) begin
      rx_data_a = d; rx_valid_a = 1'b1; sent_a++;
      if (accept) exp_a.push_back(d);
    end else begin
      rx_data_l = d; rx_valid_l = 1'b1; sent_l++;
      line_model_write(d);
    end
    @(negedge clk);
    rx_valid_a = 1'b0;
    rx_valid_l = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain(input bit line, input string name);
    int n = 0;
    while (((line ? exp_l.size() : exp_a.size()) != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
    check_output({name, "_drained"}, line ? exp_l.size() : exp_a.size(), 0);
    check_output({name, "_fifo_count"}, line ? fifo_count_l : fifo_count_a, 0);
    check_output({name, "_flush_pulses"}, line ? flush_cnt_l : flush_cnt_a, line ? sent_l : sent_a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_a.delete(); exp_l.delete(); pend_l.delete();
    sent_a = 0; sent_l = 0; flush_cnt_a = 0; flush_cnt_l = 0;
  endtask

  // Monitor: every tx_enable must match the head of the scoreboard queue.
  initial forever begin
    @(negedge clk);
    if (rx_flush_a) flush_cnt_a++;
    if (rx_flush_l) flush_cnt_l++;
    if (tx_enable_a) begin
      txen_cnt_a++;
      if (exp_a.size() == 0) check_output("a_unexpected_tx", tx_data_a, 32'hFFFF_FFFF);
      else                   check_output("a_tx_data", tx_data_a, exp_a.pop_front());
    end
    if (tx_enable_l) begin
      txen_cnt_l++;
      if (exp_l.size() == 0) check_output("l_unexpected_tx", tx_data_l, 32'hFFFF_FFFF);
      else                   check_output("l_tx_data", tx_data_l, exp_l.pop_front());
    end
  end

  // Transmitter models: random busy length, sometimes never raising busy at all.
  initial begin
    int ca = 0, cl = 0;
    forever begin
      @(negedge clk);
      if (rst) ca = 0;
      else if (tx_enable_a) ca = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 5));
      else if (ca > 0) ca--;
      if (rst) cl = 0;
      else if (tx_enable_l) cl = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 5));
      else if (cl > 0) cl--;
      busy_model_a = (ca > 0);
      busy_model_l = (cl > 0);
    end
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, txen_snap;
    do_reset();
    check_output("rst_fifo_count", fifo_count_a, 0);
    check_output("rst_overflow", overflow_a, 0);
    check_output("rst_led", led_a, 0);
    check_output("rst_tx_enable", tx_enable_a, 0);
    check_output("rst_rx_flush", rx_flush_a, 0);
    check_output("rst_tx_data", tx_data_a, 0);
    check_output("rst_l_fifo_count", fifo_count_l, 0);

    // Single character latency, flush pulse and LED hold.
    apply_stimulus(0, 8'h41, 1, 0);
    check_output("lat_flush_n1", rx_flush_a, 1);
    check_output("lat_count_n1", fifo_count_a, 1);
    check_output("lat_led_on", led_a, 1);
    check_output("lat_txen_n1", tx_enable_a, 0);
    @(negedge clk);
    check_output("lat_txen_n2", tx_enable_a, 0);
    check_output("lat_flush_n2", rx_flush_a, 0);
    @(negedge clk);
    check_output("lat_txen_n3", tx_enable_a, 1);
    check_output("lat_tx_data", tx_data_a, 8'h41);
    repeat (17) @(negedge clk);
    check_output("led_hold_last", led_a, 1);
    @(negedge clk);
    check_output("led_hold_off", led_a, 0);
    wait_drain(0, "lat");

    // Overflow: 17 characters while the transmitter is stuck busy.
    busy_force_a = 1'b1;
    for (int i = 0; i < 17; i++) apply_stimulus(0, 8'(i), (i < DEPTH), 0);
    check_output("ovf_count", fifo_count_a, 16);
    check_output("ovf_flag", overflow_a, 1);
    busy_force_a = 1'b0;
    wait_drain(0, "ovf");
    check_output("ovf_sticky", overflow_a, 1);
    do_reset();
    check_output("ovf_cleared", overflow_a, 0);

    // Write coincident with the pop at full.
    busy_force_a = 1'b1;
    for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 8'(8'h60 + i), 1, 0);
    check_output("full_count", fifo_count_a, 16);
    busy_force_a = 1'b0;
    @(negedge clk);
    rx_data_a = 8'h77; rx_valid_a = 1'b1; sent_a++; exp_a.push_back(8'h77);
    @(negedge clk);
    rx_valid_a = 1'b0;
    check_output("coinc_count", fifo_count_a, 16);
    check_output("coinc_overflow", overflow_a, 0);
    wait_drain(0, "coinc");

    // Reset in WAIT_LO with five entries queued.
    busy_force_a = 1'b1;
    for (int i = 0; i < 6; i++) apply_stimulus(0, 8'(8'hA0 + i), 1, 0);
    busy_force_a = 1'b0;
    n = 0;
    while (!tx_enable_a && n < 50) begin @(negedge clk); n++; end
    busy_force_a = 1'b1;
    check_output("wlo_reached_tx", n < 50, 1);
    repeat (3) @(negedge clk);
    check_output("wlo_count", fifo_count_a, 5);
    rst = 1'b1; rx_data_a = 8'h99; rx_valid_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; rx_valid_a = 1'b0;
    exp_a.delete(); sent_a = 0; flush_cnt_a = 0;
    check_output("wlo_rst_count", fifo_count_a, 0);
    check_output("wlo_rst_flush", rx_flush_a, 0);
    check_output("wlo_rst_led", led_a, 0);
    txen_snap = txen_cnt_a;
    busy_force_a = 1'b0;
    repeat (20) @(negedge clk);
    check_output("wlo_no_txen", txen_cnt_a, txen_snap);
    check_output("wlo_count_after", fifo_count_a, 0);
    apply_stimulus(0, 8'h5A, 1, 0);
    wait_drain(0, "wlo_echo");

    // Line mode: nothing until the terminator, then the whole line.
    txen_snap = txen_cnt_l;
    apply_stimulus(1, 8'h41, 1, 0);
    apply_stimulus(1, 8'h42, 1, 10);
    check_output("line_hold_txen", txen_cnt_l, txen_snap);
    check_output("line_hold_count", fifo_count_l, 2);
    apply_stimulus(1, TERM, 1, 0);
    wait_drain(1, "line_ab");
    txen_snap = txen_cnt_l;
    apply_stimulus(1, 8'h43, 1, 15);
    check_output("line_term_zero_txen", txen_cnt_l, txen_snap);
    check_output("line_term_zero_count", fifo_count_l, 1);
    apply_stimulus(1, TERM, 1, 0);
    wait_drain(1, "line_c");

    // Line mode forced drain of a full buffer with no terminator.
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1, 8'(8'h20 + i), 1, 0);
    wait_drain(1, "forced");

    // Randomized traffic for both modes.
    for (int b = 0; b < 6; b++) begin
      int len = int'($urandom_range(1, 10));
      for (int i = 0; i < len; i++) apply_stimulus(0, 8'($urandom), 1, int'($urandom_range(0, 3)));
      wait_drain(0, "rand_a");
    end
    for (int b = 0; b < 6; b++) begin
      int len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) apply_stimulus(1, 8'($urandom), 1, int'($urandom_range(0, 3)));
      apply_stimulus(1, TERM, 1, 0);
      wait_drain(1, "rand_l");
    end
    check_output("final_overflow_a", overflow_a, 0);
    check_output("final_overflow_l", overflow_l, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
